data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Sequencing controller between the CPU load/store stage and the byte-wide data memory (one byte read/written per access, combinational read, write on rising clk). Breaks every LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 single-byte memory cycles in little-endian order, then assembles, sign- or zero-extends and returns the load result. The CPU stalls on busy and consumes the result on the done pulse.

Parameters:
DATA_WIDTH, 32, CPU data and address width
BYTE_WIDTH, 8, memory access width per cycle

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  1  CPU access request, sampled only in IDLE
we  input  1  1 = store, 0 = load; latched on acceptance
funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; latched on acceptance
addr  input  DATA_WIDTH  byte address of first byte; latched on acceptance
wdata  input  DATA_WIDTH  store data, little-endian; latched on acceptance
rdata  output  DATA_WIDTH  extended load result, valid while done=1
busy  output  1  high from the acceptance cycle+1 through the DONE cycle
done  output  1  one-cycle pulse marking access complete
err  output  1  high with done when funct3 is illegal
mem_we  output  1  byte write enable to the data memory
mem_a  output  DATA_WIDTH  byte address to the data memory
mem_wd  output  DATA_WIDTH  write data, byte in [7:0], [31:8]=0
mem_rd  input  DATA_WIDTH  memory read data, byte in [7:0], combinational in mem_a

Behaviour:
- States: IDLE, ACCESS, DONE. Reset -> IDLE; rdata=0, done=0, err=0, busy=0, mem_we=0, mem_a=0, mem_wd=0, byte index=0, latched regs=0.
- IDLE: req=1 -> latch we/funct3/addr/wdata, idx<=0, set N = 1 (B/BU), 2 (H/HU), 4 (W). Legal funct3 -> ACCESS; illegal (011,110,111) -> DONE with err=1, rdata=0, no memory write. req=0 -> stay.
- ACCESS: mem_a = addr_l + idx (32-bit add, wraps at 0xFFFFFFFF -> 0); mem_we = we_l; mem_wd[7:0] = wdata_l byte idx. Loads capture mem_rd[7:0] into assembly byte idx at the clock edge. idx increments each cycle; when idx==N-1 -> DONE. ACCESS lasts exactly N cycles.
- DONE: exactly one cycle; done=1, busy=1, mem_we=0. rdata: B/H sign-extend from bit 7/15, BU/HU zero-extend, W raw; stores give rdata=0. Next state IDLE unconditionally.
- busy=1 in ACCESS and DONE; mem_we=0, mem_a=0, mem_wd=0 outside ACCESS.
- Total latency accept->done: N+1 cycles (illegal funct3: 1). Back-to-back throughput: one request per N+2 cycles (req held high in DONE is not accepted until the following IDLE cycle).
- req/input changes while busy are ignored; latched values stay in use.
- Misaligned addresses permitted; no alignment trap. No range check: out-of-window addresses read as 0 from the memory and are assembled as such.
- rst mid-ACCESS: next cycle IDLE, mem_we=0; bytes already written stay written, remaining bytes are not written, no done pulse.
- rdata holds its value after DONE until the next DONE or reset.

Test Plan:
- SW addr=0x00010000 wdata=0xDEADBEEF -> 4 ACCESS cycles, mem bytes 0x10000..3 = EF,BE,AD,DE; done at cycle 5 after acceptance; rdata=0.
- LW addr=0x00010000 after above -> rdata=0xDEADBEEF, done 5 cycles after acceptance, err=0.
- mem[0x10010]=0x80: LB -> rdata=0xFFFFFF80; LBU -> 0x00000080; LH with mem[0x10011]=0x7F -> 0x00007F80; LHU of 0x80FF pattern (bytes FF,80) -> 0x000080FF, LH -> 0xFFFF80FF.
- Misaligned SH addr=0x00010003 wdata=0x1234 -> bytes 0x10003=34, 0x10004=12, neighbouring bytes unchanged.
- funct3=011 req -> next cycle done=1, err=1, rdata=0, mem_we never asserted.
- SW 0x11223344 to 0x10020, assert rst during 3rd ACCESS cycle -> bytes 0x10020=44, 0x10021=33 written, 0x10022/0x10023 unchanged, no done, state IDLE, all outputs 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: splits CPU loads/stores into little-endian byte-wide memory cycles and extends load results.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic we_l;
  logic [2:0] f3_l;
  logic [DATA_WIDTH-1:0] addr_l, wdata_l, asm_l, rhold, ext;
  logic [IW-1:0] idx, last_idx;
  logic legal_in, legal_l, in_access;
  assign legal_in = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign legal_l = !(f3_l == 3'b011 || f3_l[2:1] == 2'b11);
  assign last_idx = f3_l[1] ? IW'(NB - 1) : f3_l[0] ? IW'(1) : '0;
  assign in_access = state == ACCESS;
  always_comb begin
    ext = (we_l || !legal_l) ? '0
        : f3_l[1:0] == 2'b00 ? {{(DATA_WIDTH-BYTE_WIDTH){~f3_l[2] & asm_l[BYTE_WIDTH-1]}}, asm_l[BYTE_WIDTH-1:0]}
        : f3_l[1:0] == 2'b01 ? {{(DATA_WIDTH-2*BYTE_WIDTH){~f3_l[2] & asm_l[2*BYTE_WIDTH-1]}}, asm_l[2*BYTE_WIDTH-1:0]}
        : asm_l;
  end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = req ? (legal_in ? ACCESS : DONE) : IDLE;
      ACCESS:  state_n = idx == last_idx ? DONE : ACCESS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_l    <= 1'b0;
      f3_l    <= '0;
      addr_l  <= '0;
      wdata_l <= '0;
      asm_l   <= '0;
      rhold   <= '0;
      idx     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        we_l    <= we;
        f3_l    <= funct3;
        addr_l  <= addr;
        wdata_l <= wdata;
        asm_l   <= '0;
        idx     <= '0;
      end
      if (in_access) begin
        idx <= idx + IW'(1);
        if (!we_l) asm_l[idx*BYTE_WIDTH +: BYTE_WIDTH] <= mem_rd[BYTE_WIDTH-1:0];
      end
      if (state == DONE) rhold <= ext;
    end
  end
  // rst gates the write strobe so a byte in flight on the reset edge is not committed
  assign mem_we = in_access && we_l && !rst;
  assign mem_a  = in_access ? addr_l + DATA_WIDTH'(idx) : '0;
  assign mem_wd = in_access ? DATA_WIDTH'(wdata_l[idx*BYTE_WIDTH +: BYTE_WIDTH]) : '0;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign err    = done && !legal_l;
  assign rdata  = done ? ext : rhold;
endmodule
